bin_to_bcd_display: RTL and testbench
=====================================

// Module: bin_to_bcd_display
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) feeding the
//  16-bit dispVal input of the 4-digit 7-segment display interface. Converts a 14-bit
//  unsigned value (0..9999) into four packed BCD digits so the display shows decimal.
//  Output register holds last result during conversion; the display never sees partial data.
// PARAMETERS
//  MAX_BIN    14'd9999   largest convertible input; above this ovf is set
//  CLAMP_BCD  16'h9999   bcd value presented when input exceeds MAX_BIN
// PORTS
//  clk5    in   1   5 MHz system clock, all logic on posedge
//  reset   in   1   synchronous, active-high reset
//  start   in   1   request conversion of bin; sampled only in IDLE
//  bin     in   14  unsigned binary value, sampled on the accepting edge
//  busy    out  1   high while a conversion is in progress
//  done    out  1   one-cycle pulse: bcd/ovf updated on this edge
//  bcd     out  16  packed BCD result, [15:12]=thousands .. [3:0]=units; to dispVal
//  ovf     out  1   1 = last accepted bin > MAX_BIN, bcd = CLAMP_BCD
// BEHAVIOUR
//  Reset: state IDLE, busy=0, done=0, bcd=16'h0000, ovf=0, shift reg/count cleared.
//   Reset mid-conversion aborts; no done pulse; bcd returns to 0.
//  States: IDLE -> SHIFT -> IDLE.
//   IDLE: start=1 at edge E0 -> load 30-bit shift reg {16'b0, bin}, count=0,
//         latch over=(bin>MAX_BIN), busy<=1, go SHIFT. start=0 -> stay.
//   SHIFT: each edge, every BCD nibble >=5 gets +3 (combinational, in parallel),
//         then whole reg shifts left 1; count increments. Edges E1..E14.
//   On E14 (count reaches 13 before the edge): bcd <= over ? CLAMP_BCD : corrected upper
//         16 bits; ovf <= over; done <= 1; busy <= 0; go IDLE.
//  done: high exactly one cycle (after E14), cleared on E15 unless reset.
//  Latency: fixed 14 clocks start-edge to done-edge, including the overflow case.
//  start while busy (E1..E14 inclusive) ignored, not queued. Earliest next accept: E15.
//  start held high continuously: back-to-back conversions, one accept per 15 clocks.
//  bin may change after E0 without effect; bcd/ovf change only on done edge.
//  Nibble correction widths: 4-bit add, no carry out (nibble<=9 guaranteed in range).
//  bin=0 -> bcd=16'h0000; bin=9999 -> 16'h9999, ovf=0; bin=10000..16383 -> clamp, ovf=1.
// TESTING
//  T1 reset then idle: bcd=16'h0000, busy=0, done=0, ovf=0 for 20 clocks, no start.
//  T2 bin=14'd1234, start 1 clk -> busy next cycle, done exactly 14 clks later, bcd=16'h1234.
//  T3 bin=9999 -> bcd=16'h9999 ovf=0; bin=10000 -> bcd=16'h9999 ovf=1; bin=0 -> 16'h0000 ovf=0.
//  T4 start again at E5 with bin=42 during 1234 conversion -> ignored, result 16'h1234, one done.
//  T5 reset asserted at E7 of conversion of 5678 -> no done, bcd=0, next start(77) -> 16'h0077.
//  T6 start held high, bin stepped 0..9999 each accept -> every done matches decimal ref model.

Source files
------------

// File: rtl/bin_to_bcd_display_if.sv
// Bundle of the converter's request/result signals between a requester and the
// binary-to-BCD display converter.
interface bin_to_bcd_display_if;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        ovf;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  ovf
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output ovf
    );
endinterface

// File: rtl/bin_to_bcd_display.sv
// Sequential shift-and-add-3 converter: turns a 14-bit binary value into four packed
// BCD digits for the 7-segment display, one input bit per clock, 14 clocks per result.
module bin_to_bcd_display #(
    parameter logic [13:0] MAX_BIN   = 14'd9999,
    parameter logic [15:0] CLAMP_BCD = 16'h9999
) (
    input  logic                  clk5,
    input  logic                  reset,
    bin_to_bcd_display_if.slave   bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;
    localparam logic [3:0] LAST_CNT = 4'd13;

    logic [0:0]  state_q, state_d;
    logic [29:0] sreg_q,  sreg_d;
    logic [3:0]  count_q, count_d;
    logic        over_q,  over_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic [15:0] bcd_q,   bcd_d;
    logic        ovf_q,   ovf_d;

    logic [29:0] corr_s;
    logic [29:0] shifted_s;

    // Digit correction: a nibble of 5..9 becomes 8..12, so the shift carries into the next digit.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // Correct all four BCD digits in parallel, then shift the whole register left by one.
    always_comb begin
        corr_s         = sreg_q;
        corr_s[29:26]  = add3(sreg_q[29:26]);
        corr_s[25:22]  = add3(sreg_q[25:22]);
        corr_s[21:18]  = add3(sreg_q[21:18]);
        corr_s[17:14]  = add3(sreg_q[17:14]);
        shifted_s      = {corr_s[28:0], 1'b0};
    end

    // Conversion sequencing and result register update.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        count_d = count_q;
        over_d  = over_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sreg_d  = {16'h0000, bus.bin};
                    count_d = 4'd0;
                    over_d  = (bus.bin > MAX_BIN);
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                sreg_d  = shifted_s;
                count_d = count_q + 4'd1;
                // The final shift lands the finished digits in the upper 16 bits.
                if (count_q == LAST_CNT) begin
                    bcd_d   = over_q ? CLAMP_BCD : shifted_s[29:14];
                    ovf_d   = over_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk5) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sreg_q  <= 30'd0;
            count_q <= 4'd0;
            over_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= 16'h0000;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            count_q <= count_d;
            over_q  <= over_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Randomized self-checking bench for bin_to_bcd_display against a decimal-arithmetic
// timing model (accept when idle, result 14 clocks later).
module tb_bin_to_bcd_display;

    logic clk5  = 1'b0;
    logic reset = 1'b1;

    bin_to_bcd_display_if bus_if ();

    bin_to_bcd_display dut (
        .clk5  (clk5),
        .reset (reset),
        .bus   (bus_if)
    );

    always #100 clk5 = ~clk5;

    int n_tests = 0;
    int n_fail  = 0;
    int dut_done_cnt = 0;

    // Behavioural model state.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_bcd  = 16'h0000;
    logic        m_ovf  = 1'b0;
    int          m_left = 0;
    logic [15:0] pend_bcd = 16'h0000;
    logic        pend_ovf = 1'b0;

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        if (v > 9999) begin
            r = 16'h9999;
        end else begin
            r[15:12] = 4'((v / 1000) % 10);
            r[11:8]  = 4'((v / 100) % 10);
            r[7:4]   = 4'((v / 10) % 10);
            r[3:0]   = 4'(v % 10);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: accept start when idle, deliver the decimal result 14 edges later.
    always @(posedge clk5) begin
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_bcd  = 16'h0000;
            m_ovf  = 1'b0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_bcd  = pend_bcd;
                    m_ovf  = pend_ovf;
                end
            end else if (bus_if.start) begin
                m_busy   = 1'b1;
                m_left   = 14;
                pend_bcd = ref_bcd(int'(bus_if.bin));
                pend_ovf = (bus_if.bin > 14'd9999);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(posedge clk5) begin
        #1;
        if (bus_if.done === 1'b1) dut_done_cnt++;
        check("cycle_outputs",
              {12'h000, bus_if.busy, bus_if.done, bus_if.ovf, bus_if.bcd, 1'b0},
              {12'h000, m_busy, m_done, m_ovf, m_bcd, 1'b0});
    end

    task automatic step();
        @(negedge clk5);
    endtask

    // Pulse start for one clock and wait (bounded) for done; lat counts clocks after the accept.
    task automatic run_conv(input logic [13:0] v, output int lat);
        bus_if.bin   = v;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        check("busy_after_accept", {31'd0, bus_if.busy}, 32'd1);
        lat = 0;
        while (bus_if.done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        if (lat >= 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d clocks for bin %0d", lat, v);
        end
    endtask

    initial begin
        int lat;
        int d0;
        int n_acc;
        int idx;
        logic [13:0] nv;

        bus_if.start = 1'b0;
        bus_if.bin   = 14'd0;

        // Pin the reference arithmetic itself.
        check("ref_1234",  {16'h0, ref_bcd(1234)},  32'h0000_1234);
        check("ref_0",     {16'h0, ref_bcd(0)},     32'h0000_0000);
        check("ref_9999",  {16'h0, ref_bcd(9999)},  32'h0000_9999);
        check("ref_10000", {16'h0, ref_bcd(10000)}, 32'h0000_9999);
        check("ref_507",   {16'h0, ref_bcd(507)},   32'h0000_0507);

        // T1: reset then idle for 20 clocks.
        step(); step(); step();
        reset = 1'b0;
        repeat (20) step();
        check("t1_bcd",  {16'h0, bus_if.bcd}, 32'h0);
        check("t1_busy", {31'd0, bus_if.busy}, 32'd0);
        check("t1_done", {31'd0, bus_if.done}, 32'd0);
        check("t1_ovf",  {31'd0, bus_if.ovf},  32'd0);

        // T2: single conversion latency and value.
        run_conv(14'd1234, lat);
        check("t2_latency", lat, 32'd14);
        check("t2_bcd", {16'h0, bus_if.bcd}, 32'h1234);
        step();
        check("t2_done_one_cycle", {31'd0, bus_if.done}, 32'd0);

        // T3: boundaries.
        run_conv(14'd9999, lat);
        check("t3_9999_bcd", {16'h0, bus_if.bcd}, 32'h9999);
        check("t3_9999_ovf", {31'd0, bus_if.ovf}, 32'd0);
        step();
        run_conv(14'd10000, lat);
        check("t3_10000_lat", lat, 32'd14);
        check("t3_10000_bcd", {16'h0, bus_if.bcd}, 32'h9999);
        check("t3_10000_ovf", {31'd0, bus_if.ovf}, 32'd1);
        step();
        run_conv(14'd0, lat);
        check("t3_0_bcd", {16'h0, bus_if.bcd}, 32'h0000);
        check("t3_0_ovf", {31'd0, bus_if.ovf}, 32'd0);
        step();

        // T4: start during conversion is ignored.
        d0 = dut_done_cnt;
        bus_if.bin   = 14'd1234;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        repeat (4) step();
        bus_if.bin   = 14'd42;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        repeat (30) step();
        check("t4_done_count", dut_done_cnt - d0, 32'd1);
        check("t4_bcd", {16'h0, bus_if.bcd}, 32'h1234);

        // T5: reset mid-conversion aborts.
        d0 = dut_done_cnt;
        bus_if.bin   = 14'd5678;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        repeat (6) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (20) step();
        check("t5_no_done", dut_done_cnt - d0, 32'd0);
        check("t5_bcd_cleared", {16'h0, bus_if.bcd}, 32'h0);
        run_conv(14'd77, lat);
        check("t5_after_bcd", {16'h0, bus_if.bcd}, 32'h0077);
        step();

        // T6: start held high, new bin on each accept.
        d0    = dut_done_cnt;
        n_acc = 0;
        idx   = 0;
        bus_if.start = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!m_busy) begin
                case (idx)
                    0: nv = 14'd0;
                    1: nv = 14'd9999;
                    2: nv = 14'd10000;
                    3: nv = 14'd16383;
                    default: begin
                        if (idx % 2 == 1) nv = 14'((idx * 487) % 10000);
                        else              nv = 14'($urandom_range(0, 16383));
                    end
                endcase
                bus_if.bin = nv;
                idx++;
                n_acc++;
            end
            step();
        end
        bus_if.start = 1'b0;
        repeat (20) step();
        check("t6_done_count", dut_done_cnt - d0, n_acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
